// File: rtl/collision_search_scheduler_if.sv
// -----------------------------------------------------------------------------
// collision_search_scheduler_if
//
// Purpose: bundles the command side (from the custom-instruction decode) and
// the searcher-array side of the collision search scheduler.
//
// Signals:
//   cmd_start      decode -> sched   one-cycle pulse, begin a new search
//   cmd_abort      decode -> sched   one-cycle pulse, cancel active search
//   target_in      decode -> sched   target value, sampled with cmd_start
//   srch_idle      array  -> sched   searcher i ready for a chunk
//   srch_hit       array  -> sched   searcher i found a collision (pulse)
//   srch_exhausted array  -> sched   searcher i finished chunk, no hit (pulse)
//   srch_result    array  -> sched   counter of searcher i at [32i+31:32i]
//   srch_start     sched  -> array   one-hot chunk dispatch pulse
//   srch_base      sched  -> array   chunk base counter
//   srch_target    sched  -> array   latched target
//   srch_kill      sched  -> array   abandon all work (pulse)
//   busy/found/exhausted/result/chunks_done  sched -> decode status
//
// Modports: master = scheduler side, slave = decode/searcher side.
// -----------------------------------------------------------------------------
interface collision_search_scheduler_if #(
  parameter int NUM_SEARCHERS = 4
);
  logic                         cmd_start;
  logic                         cmd_abort;
  logic [31:0]                  target_in;
  logic [NUM_SEARCHERS-1:0]     srch_idle;
  logic [NUM_SEARCHERS-1:0]     srch_hit;
  logic [NUM_SEARCHERS-1:0]     srch_exhausted;
  logic [32*NUM_SEARCHERS-1:0]  srch_result;
  logic [NUM_SEARCHERS-1:0]     srch_start;
  logic [31:0]                  srch_base;
  logic [31:0]                  srch_target;
  logic                         srch_kill;
  logic                         busy;
  logic                         found;
  logic                         exhausted;
  logic [31:0]                  result;
  logic [31:0]                  chunks_done;

  modport master (
    input  cmd_start, cmd_abort, target_in,
    input  srch_idle, srch_hit, srch_exhausted, srch_result,
    output srch_start, srch_base, srch_target, srch_kill,
    output busy, found, exhausted, result, chunks_done
  );

  modport slave (
    output cmd_start, cmd_abort, target_in,
    output srch_idle, srch_hit, srch_exhausted, srch_result,
    input  srch_start, srch_base, srch_target, srch_kill,
    input  busy, found, exhausted, result, chunks_done
  );
endinterface

// File: rtl/collision_search_scheduler.sv
// -----------------------------------------------------------------------------
// collision_search_scheduler
//
// Purpose: deals fixed-size counter chunks of the 32-bit counter space to a
// pool of SHA-1 collision searcher cores on demand. The first valid hit is
// latched and all searchers are killed; if every chunk comes back empty the
// search reports exhausted.
//
// Ports:
//   wClock  clock
//   reset   asynchronous, active-high reset
//   bus     collision_search_scheduler_if.master (command, searcher and
//           status signals)
//
// Parameters:
//   NUM_SEARCHERS  number of searcher cores (1..16)
//   CHUNK_WIDTH    log2 of counters per chunk (8..31)
// -----------------------------------------------------------------------------
module collision_search_scheduler #(
  parameter int NUM_SEARCHERS = 4,
  parameter int CHUNK_WIDTH   = 24
) (
  input  logic                           wClock,
  input  logic                           reset,
  collision_search_scheduler_if.master   bus
);

  // Issue counter must be able to hold TOTAL_CHUNKS itself, hence one extra bit.
  localparam int                ICW          = 33 - CHUNK_WIDTH;
  localparam logic [ICW-1:0]    TOTAL_CHUNKS = ICW'(1) << (32 - CHUNK_WIDTH);
  localparam logic [31:0]       CHUNK_STEP   = 32'd1 << CHUNK_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_DRAIN,
    ST_FOUND,
    ST_EXHAUSTED
  } state_t;

  state_t                    state_q, state_d;
  logic [NUM_SEARCHERS-1:0]  outstanding_q, outstanding_d;
  logic [31:0]               next_base_q, next_base_d;
  logic [ICW-1:0]            issue_cnt_q, issue_cnt_d;
  logic [31:0]               target_q, target_d;
  logic                      found_q, found_d;
  logic                      exhausted_q, exhausted_d;
  logic [31:0]               result_q, result_d;
  logic [31:0]               chunks_done_q, chunks_done_d;
  logic [NUM_SEARCHERS-1:0]  srch_start_q, srch_start_d;
  logic [31:0]               srch_base_q, srch_base_d;
  logic                      srch_kill_q, srch_kill_d;
  logic                      busy_q, busy_d;

  // Pulses only count for searchers that actually own a chunk; anything else
  // is a leftover from before a kill.
  logic [NUM_SEARCHERS-1:0]  valid_hit;
  logic [NUM_SEARCHERS-1:0]  valid_exh;
  logic [NUM_SEARCHERS-1:0]  disp_cand;
  logic [NUM_SEARCHERS-1:0]  disp_pick;
  logic [NUM_SEARCHERS-1:0]  hit_pick;
  logic [31:0]               hit_value;
  logic [31:0]               lane_masked [NUM_SEARCHERS];
  logic [5:0]                done_inc;
  logic [32:0]               done_sum;
  logic [31:0]               done_sat;

  assign valid_hit = bus.srch_hit & outstanding_q;
  assign valid_exh = bus.srch_exhausted & outstanding_q;

  // Dispatch decision uses the registered mask, so a searcher whose exhausted
  // pulse arrives this cycle is not re-dispatched until the next one.
  assign disp_cand = bus.srch_idle & ~outstanding_q;

  // x & -x isolates the lowest set bit: lowest-index priority select.
  assign disp_pick = disp_cand & (-disp_cand);
  assign hit_pick  = valid_hit & (-valid_hit);

  generate
    for (genvar gi = 0; gi < NUM_SEARCHERS; gi++) begin : g_lane
      assign lane_masked[gi] = hit_pick[gi] ? bus.srch_result[32*gi +: 32] : 32'd0;
    end
  endgenerate

  // hit_pick is one-hot (or zero), so OR-ing the masked lanes is a mux.
  always_comb begin
    hit_value = 32'd0;
    for (int i = 0; i < NUM_SEARCHERS; i++) begin
      hit_value = hit_value | lane_masked[i];
    end
  end

  always_comb begin
    done_inc = 6'd0;
    for (int i = 0; i < NUM_SEARCHERS; i++) begin
      done_inc = done_inc + 6'(valid_exh[i]);
    end
  end

  assign done_sum = {1'b0, chunks_done_q} + {27'd0, done_inc};
  assign done_sat = done_sum[32] ? 32'hFFFF_FFFF : done_sum[31:0];

  // State register
  always_ff @(posedge wClock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      outstanding_q <= '0;
      next_base_q   <= 32'd0;
      issue_cnt_q   <= '0;
      target_q      <= 32'd0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      result_q      <= 32'd0;
      chunks_done_q <= 32'd0;
      srch_start_q  <= '0;
      srch_base_q   <= 32'd0;
      srch_kill_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      next_base_q   <= next_base_d;
      issue_cnt_q   <= issue_cnt_d;
      target_q      <= target_d;
      found_q       <= found_d;
      exhausted_q   <= exhausted_d;
      result_q      <= result_d;
      chunks_done_q <= chunks_done_d;
      srch_start_q  <= srch_start_d;
      srch_base_q   <= srch_base_d;
      srch_kill_q   <= srch_kill_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q;
    next_base_d   = next_base_q;
    issue_cnt_d   = issue_cnt_q;
    target_d      = target_q;
    found_d       = found_q;
    exhausted_d   = exhausted_q;
    result_d      = result_q;
    chunks_done_d = chunks_done_q;
    srch_start_d  = '0;
    srch_base_d   = srch_base_q;
    srch_kill_d   = 1'b0;

    case (state_q)
      ST_DISPATCH, ST_DRAIN: begin
        // Completions are always counted, even in a hit or abort cycle.
        chunks_done_d = done_sat;
        outstanding_d = outstanding_q & ~valid_exh;

        if (bus.cmd_abort) begin
          srch_kill_d   = 1'b1;
          outstanding_d = '0;
          state_d       = ST_IDLE;
        end else if (|valid_hit) begin
          result_d      = hit_value;
          found_d       = 1'b1;
          srch_kill_d   = 1'b1;
          outstanding_d = '0;
          state_d       = ST_FOUND;
        end else if (state_q == ST_DISPATCH) begin
          if (|disp_pick) begin
            srch_start_d  = disp_pick;
            srch_base_d   = next_base_q;
            outstanding_d = outstanding_d | disp_pick;
            next_base_d   = next_base_q + CHUNK_STEP;
            issue_cnt_d   = issue_cnt_q + ICW'(1);
            if (issue_cnt_d == TOTAL_CHUNKS) begin
              state_d = ST_DRAIN;
            end
          end
        end else if (outstanding_d == '0) begin
          // Last chunk came back empty this cycle.
          exhausted_d = 1'b1;
          state_d     = ST_EXHAUSTED;
        end
      end

      ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
        if (bus.cmd_start) begin
          target_d      = bus.target_in;
          found_d       = 1'b0;
          exhausted_d   = 1'b0;
          result_d      = 32'd0;
          chunks_done_d = 32'd0;
          outstanding_d = '0;
          next_base_d   = 32'd0;
          issue_cnt_d   = '0;
          state_d       = ST_DISPATCH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_DISPATCH) || (state_d == ST_DRAIN);
  end

  assign bus.srch_start  = srch_start_q;
  assign bus.srch_base   = srch_base_q;
  assign bus.srch_target = target_q;
  assign bus.srch_kill   = srch_kill_q;
  assign bus.busy        = busy_q;
  assign bus.found       = found_q;
  assign bus.exhausted   = exhausted_q;
  assign bus.result      = result_q;
  assign bus.chunks_done = chunks_done_q;

endmodule

// File: tb/tb_collision_search_scheduler.sv
// -----------------------------------------------------------------------------
// tb_collision_search_scheduler
//
// Purpose: directed self-checking bench for collision_search_scheduler with
// NUM_SEARCHERS=4, CHUNK_WIDTH=28 (16 chunks of 2^28 counters).
// -----------------------------------------------------------------------------
module tb_collision_search_scheduler;

  localparam int N  = 4;
  localparam int CW = 28;

  logic wClock = 1'b0;
  logic reset;

  always #5 wClock = ~wClock;

  collision_search_scheduler_if #(.NUM_SEARCHERS(N)) bus ();

  collision_search_scheduler #(
    .NUM_SEARCHERS(N),
    .CHUNK_WIDTH  (CW)
  ) dut (
    .wClock(wClock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Searcher model state: replies exhausted a fixed delay after dispatch.
  bit          auto_en;
  int          cnt [N];
  logic [31:0] seen_base  [$];
  logic [3:0]  seen_start [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge, then drop all
  // one-cycle input pulses and run the searcher model.
  task automatic cycle();
    @(posedge wClock);
    #1;
    bus.cmd_start      = 1'b0;
    bus.cmd_abort      = 1'b0;
    bus.srch_hit       = '0;
    bus.srch_exhausted = '0;
    if (|bus.srch_start) begin
      seen_base.push_back(bus.srch_base);
      seen_start.push_back(bus.srch_start);
    end
    if (auto_en) begin
      for (int i = 0; i < N; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) bus.srch_exhausted[i] = 1'b1;
        end
        if (bus.srch_start[i]) cnt[i] = 3;
      end
    end
  endtask

  initial begin
    logic [31:0] exp_base;
    logic [3:0]  exp_start;

    reset              = 1'b1;
    bus.cmd_start      = 1'b0;
    bus.cmd_abort      = 1'b0;
    bus.target_in      = 32'd0;
    bus.srch_idle      = '0;
    bus.srch_hit       = '0;
    bus.srch_exhausted = '0;
    bus.srch_result    = '0;
    auto_en            = 1'b0;
    for (int i = 0; i < N; i++) cnt[i] = 0;

    // Reset state
    #12;
    check_val("rst_busy",        32'(bus.busy),       32'd0);
    check_val("rst_found",       32'(bus.found),      32'd0);
    check_val("rst_exhausted",   32'(bus.exhausted),  32'd0);
    check_val("rst_srch_start",  32'(bus.srch_start), 32'd0);
    check_val("rst_srch_kill",   32'(bus.srch_kill),  32'd0);
    check_val("rst_srch_target", bus.srch_target,     32'd0);
    check_val("rst_srch_base",   bus.srch_base,       32'd0);
    check_val("rst_result",      bus.result,          32'd0);
    check_val("rst_chunks_done", bus.chunks_done,     32'd0);
    @(posedge wClock);
    #1;
    reset = 1'b0;

    // Full sweep with every chunk coming back empty
    bus.target_in = 32'hDEADBEEF;
    bus.srch_idle = 4'b1111;
    auto_en       = 1'b1;
    bus.cmd_start = 1'b1;
    cycle();
    check_val("sweep_busy",        32'(bus.busy),       32'd1);
    check_val("sweep_target",      bus.srch_target,     32'hDEADBEEF);
    check_val("sweep_no_start_e0", 32'(bus.srch_start), 32'd0);
    for (int k = 0; k < 300 && !bus.exhausted; k++) cycle();
    check_val("sweep_exhausted",   32'(bus.exhausted),  32'd1);
    check_val("sweep_dispatches",  32'(seen_base.size()), 32'd16);
    for (int j = 0; j < 16; j++) begin
      exp_base = 32'(j) << CW;
      check_val($sformatf("sweep_base_%0d", j), (j < seen_base.size()) ? seen_base[j] : 32'hXXXXXXXX, exp_base);
    end
    for (int j = 0; j < 4; j++) begin
      exp_start = 4'b0001 << j;
      check_val($sformatf("sweep_start_%0d", j), (j < seen_start.size()) ? 32'(seen_start[j]) : 32'hXXXXXXXX, 32'(exp_start));
    end
    check_val("sweep_chunks_done", bus.chunks_done,     32'd16);
    check_val("sweep_busy_end",    32'(bus.busy),       32'd0);
    check_val("sweep_found",       32'(bus.found),      32'd0);

    // Double hit: lowest index wins
    auto_en = 1'b0;
    repeat (6) cycle();
    seen_base.delete();
    seen_start.delete();
    bus.srch_idle = 4'b0111;
    bus.target_in = 32'h0BADF00D;
    bus.cmd_start = 1'b1;
    cycle();
    check_val("hit_exh_cleared",   32'(bus.exhausted),  32'd0);
    check_val("hit_chunks_clear",  bus.chunks_done,     32'd0);
    repeat (3) cycle();
    check_val("hit_dispatched",    32'(seen_base.size()), 32'd3);
    bus.srch_idle   = 4'b1111;
    bus.srch_hit    = 4'b0110;
    bus.srch_result = {32'h3000ABCD, 32'h2000ABCD, 32'h1000ABCD, 32'h0000ABCD};
    cycle();
    check_val("hit_result",        bus.result,          32'h1000ABCD);
    check_val("hit_found",         32'(bus.found),      32'd1);
    check_val("hit_kill",          32'(bus.srch_kill),  32'd1);
    check_val("hit_no_start",      32'(bus.srch_start), 32'd0);
    check_val("hit_busy",          32'(bus.busy),       32'd0);
    cycle();
    check_val("hit_kill_once",     32'(bus.srch_kill),  32'd0);
    check_val("hit_found_sticky",  32'(bus.found),      32'd1);

    // Abort beats a same-cycle hit
    bus.srch_idle = 4'b0001;
    bus.target_in = 32'hCAFEF00D;
    bus.cmd_start = 1'b1;
    cycle();
    check_val("abt_found_clear",   32'(bus.found),      32'd0);
    check_val("abt_result_clear",  bus.result,          32'd0);
    cycle();
    check_val("abt_start0",        32'(bus.srch_start), 32'd1);
    bus.cmd_abort   = 1'b1;
    bus.srch_hit    = 4'b0001;
    bus.srch_result = {32'h0, 32'h0, 32'h0, 32'h12345678};
    cycle();
    check_val("abt_busy",          32'(bus.busy),       32'd0);
    check_val("abt_found",         32'(bus.found),      32'd0);
    check_val("abt_exhausted",     32'(bus.exhausted),  32'd0);
    check_val("abt_kill",          32'(bus.srch_kill),  32'd1);
    check_val("abt_result",        bus.result,          32'd0);
    bus.srch_exhausted = 4'b0001;
    cycle();
    check_val("abt_stale_idle",    bus.chunks_done,     32'd0);

    // Restart after abort
    bus.srch_idle = 4'b0011;
    bus.cmd_start = 1'b1;
    cycle();
    check_val("rs_busy",           32'(bus.busy),       32'd1);
    check_val("rs_chunks_done",    bus.chunks_done,     32'd0);
    cycle();
    check_val("rs_start_a",        32'(bus.srch_start), 32'd1);
    check_val("rs_base_a",         bus.srch_base,       32'h00000000);
    cycle();
    check_val("rs_start_b",        32'(bus.srch_start), 32'd2);
    check_val("rs_base_b",         bus.srch_base,       32'h10000000);

    // Stale exhausted[3] and cmd_start while busy are ignored
    bus.srch_exhausted = 4'b1000;
    bus.target_in      = 32'h11111111;
    bus.cmd_start      = 1'b1;
    cycle();
    check_val("stale_chunks",      bus.chunks_done,     32'd0);
    check_val("stale_target",      bus.srch_target,     32'hCAFEF00D);
    check_val("stale_busy",        32'(bus.busy),       32'd1);
    check_val("stale_no_start",    32'(bus.srch_start), 32'd0);

    // Two completions in one cycle; no re-dispatch on that same edge
    bus.srch_exhausted = 4'b0011;
    cycle();
    check_val("pop_chunks",        bus.chunks_done,     32'd2);
    check_val("pop_no_redispatch", 32'(bus.srch_start), 32'd0);
    bus.srch_idle = 4'b0111;
    cycle();
    check_val("redisp_start_a",    32'(bus.srch_start), 32'd1);
    check_val("redisp_base_a",     bus.srch_base,       32'h20000000);
    cycle();
    check_val("redisp_base_b",     bus.srch_base,       32'h30000000);
    cycle();
    check_val("redisp_start_c",    32'(bus.srch_start), 32'd4);
    check_val("redisp_base_c",     bus.srch_base,       32'h40000000);

    // Asynchronous reset mid-search with 3 chunks outstanding
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_busy",         32'(bus.busy),       32'd0);
    check_val("arst_start",        32'(bus.srch_start), 32'd0);
    check_val("arst_base",         bus.srch_base,       32'd0);
    check_val("arst_target",       bus.srch_target,     32'd0);
    check_val("arst_chunks",       bus.chunks_done,     32'd0);
    check_val("arst_kill",         32'(bus.srch_kill),  32'd0);
    #1;
    reset         = 1'b0;
    bus.srch_idle = 4'b1111;
    bus.target_in = 32'hDEADBEEF;
    bus.cmd_start = 1'b1;
    cycle();
    cycle();
    check_val("arst_restart_start", 32'(bus.srch_start), 32'd1);
    check_val("arst_restart_base",  bus.srch_base,       32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
